// File: rtl/uart_rx_pkg.sv
// Shared types, legal prescale values and the parity helper for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int unsigned PRESCALE_8      = 8;
    localparam int unsigned PRESCALE_16     = 16;
    localparam int unsigned PRESCALE_32     = 32;
    localparam int unsigned MAX_DATA_WIDTH  = 32;

    // Zero-extension is harmless: extra zero bits do not change the XOR.
    function automatic logic expected_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                             input logic                      par_typ);
        return (^data) ^ par_typ;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and 3-sample majority vote around the bit centre.
module uart_rx_sampler #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      res_i,
    input  logic                      start_i,
    input  logic                      run_i,
    input  logic                      rx_s_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      sample_done_o,
    output logic                      bit_end_o,
    output logic                      bit_val_o
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_WIDTH-1:0] half, last;
    logic                      s0_q, s0_d;
    logic                      s1_q, s1_d;

    always_comb begin
        half          = prescale_i >> 1;
        last          = prescale_i - ONE;
        edge_cnt_d    = '0;
        s0_d          = s0_q;
        s1_d          = s1_q;
        sample_done_o = 1'b0;
        bit_end_o     = 1'b0;
        // Start detection happens on count 0, so the first START cycle is count 1.
        if (start_i) begin
            edge_cnt_d = ONE;
        end else if (run_i) begin
            edge_cnt_d = (edge_cnt_q == last) ? '0 : edge_cnt_q + ONE;
            if (edge_cnt_q == half - ONE) s0_d = rx_s_i;
            if (edge_cnt_q == half)       s1_d = rx_s_i;
            sample_done_o = (edge_cnt_q == half + ONE);
            bit_end_o     = (edge_cnt_q == last);
        end
        bit_val_o = (s0_q & s1_q) | (s0_q & rx_s_i) | (s1_q & rx_s_i);
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: input synchronizer, frame FSM, LSB-first shift register and
// mutually exclusive result strobes (stp_err > par_err > data_valid).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      par_en,
    input  logic                      par_typ,
    output logic [DATA_WIDTH-1:0]     p_data,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      busy
);

    localparam int unsigned       CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e                 state_q, state_d;
    logic                      sync1_q, rx_s_q, rx_prev_q;
    logic [1:0]                sync_vld_q;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      err_q, err_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;

    logic start_det;
    logic sample_done, bit_end, bit_val;

    // rx_prev only reports a genuine high once post-reset data has filled the
    // synchronizer, so a line held low through reset cannot fake a start edge.
    always_ff @(posedge clk) begin
        if (res) begin
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            sync_vld_q <= '0;
            rx_prev_q  <= 1'b0;
        end else begin
            sync1_q    <= rx_in;
            rx_s_q     <= sync1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            rx_prev_q  <= sync_vld_q[1] & rx_s_q;
        end
    end

    assign start_det = (state_q == IDLE) && rx_prev_q && !rx_s_q;

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .clk_i        (clk),
        .res_i        (res),
        .start_i      (start_det),
        .run_i        (state_q != IDLE),
        .rx_s_i       (rx_s_q),
        .prescale_i   (prescale_q),
        .sample_done_o(sample_done),
        .bit_end_o    (bit_end),
        .bit_val_o    (bit_val)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        err_d        = err_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d    = START;
                    bit_cnt_d  = '0;
                    err_d      = 1'b0;
                    prescale_d = prescale;
                    par_en_d   = par_en;
                    par_typ_d  = par_typ;
                end
            end
            START: begin
                if (sample_done && bit_val) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_done) shift_d[bit_cnt_q] = bit_val;
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (sample_done &&
                    (bit_val != expected_parity(MAX_DATA_WIDTH'(shift_q), par_typ_q))) begin
                    err_d = 1'b1;
                end
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Leaving at mid-bit lets a back-to-back start edge be caught.
                if (sample_done) begin
                    state_d = IDLE;
                    if (!bit_val) begin
                        stp_err_d = 1'b1;
                    end else if (err_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            err_q        <= 1'b0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            err_q        <= err_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames scored
// against a frame-level reference model.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          res;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          par_typ;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    int            cyc = 0;
    int            dv_cnt = 0, pe_cnt = 0, se_cnt = 0, wide_cnt = 0;
    int            last_dv_cyc = 0;
    logic          busy_seen = 1'b0;
    logic          prev_dv = 1'b0, prev_pe = 1'b0, prev_se = 1'b0;
    logic [DW-1:0] dv_q[$];
    logic [DW-1:0] model_pdata = '0;
    int            ps_tab[3];

    uart_rx #(
        .DATA_WIDTH    (DW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clk       (clk),
        .res       (res),
        .rx_in     (rx_in),
        .prescale  (prescale),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_cnt++;
            dv_q.push_back(p_data);
            last_dv_cyc = cyc;
        end
        if (par_err === 1'b1) pe_cnt++;
        if (stp_err === 1'b1) se_cnt++;
        if ((data_valid && prev_dv) || (par_err && prev_pe) || (stp_err && prev_se)) wide_cnt++;
        if ((int'(data_valid) + int'(par_err) + int'(stp_err)) > 1) wide_cnt++;
        prev_dv = data_valid;
        prev_pe = par_err;
        prev_se = stp_err;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Parity bit that makes the total count of ones even (par_typ=0) or odd (par_typ=1).
    function automatic logic ref_parity(input logic [DW-1:0] d, input logic pt);
        int ones;
        ones = $countones(d);
        return pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic drive_bit(input logic b, input int ps, input logic glitch);
        for (int i = 0; i < ps; i++) begin
            @(negedge clk);
            rx_in = (glitch && i == ps / 2) ? ~b : b;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_in = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int ps, input logic pe,
                              input logic pbit, input logic stop, input int glitch_bit,
                              output int stop_c);
        drive_bit(1'b0, ps, 1'b0);
        for (int k = 0; k < DW; k++) drive_bit(d[k], ps, k == glitch_bit);
        if (pe) drive_bit(pbit, ps, 1'b0);
        @(negedge clk);
        rx_in  = stop;
        stop_c = cyc;
        for (int i = 1; i < ps; i++) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [DW-1:0] d, input int ps,
                             input logic pe, input logic pt, input logic pbit_ok,
                             input logic stop, input int glitch_bit);
        int   dv0, pe0, se0, stop_c;
        logic exp_dv, exp_pe, exp_se;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        dv_q.delete();
        prescale = PW'(ps);
        par_en   = pe;
        par_typ  = pt;
        send_frame(d, ps, pe, ref_parity(d, pt) ^ ~pbit_ok, stop, glitch_bit, stop_c);
        idle(ps + 4);
        exp_se = ~stop;
        exp_pe = stop & pe & ~pbit_ok;
        exp_dv = stop & ~(pe & ~pbit_ok);
        if (exp_dv) model_pdata = d;
        check({tag, ":data_valid"}, dv_cnt - dv0, 32'(exp_dv));
        check({tag, ":par_err"}, pe_cnt - pe0, 32'(exp_pe));
        check({tag, ":stp_err"}, se_cnt - se0, 32'(exp_se));
        check({tag, ":p_data"}, 32'(p_data), 32'(model_pdata));
        check({tag, ":busy"}, 32'(busy), 0);
        if (exp_dv) begin
            check({tag, ":latency"}, last_dv_cyc - stop_c, ps / 2 + 4);
            check({tag, ":strobe_word"}, (dv_q.size() > 0) ? 32'(dv_q[0]) : 32'hDEAD, 32'(d));
        end
    endtask

    initial begin
        int   dv0, pe0, se0, dummy;
        logic [DW-1:0] rd;
        int   rps;
        logic rpe, rpt, rok, rstop;

        ps_tab[0] = PRESCALE_8;
        ps_tab[1] = PRESCALE_16;
        ps_tab[2] = PRESCALE_32;

        // Reset with the line held low, then a break that must not start a frame.
        res = 1'b1; rx_in = 1'b0; prescale = PW'(8); par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst:p_data", 32'(p_data), 0);
        check("rst:data_valid", 32'(data_valid), 0);
        check("rst:par_err", 32'(par_err), 0);
        check("rst:stp_err", 32'(stp_err), 0);
        check("rst:busy", 32'(busy), 0);
        res = 1'b0;
        busy_seen = 1'b0;
        repeat (40) @(negedge clk);
        check("break:no_start", 32'(busy_seen), 0);
        idle(10);

        run_frame("good8", 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        run_frame("good16", 8'h3C, 16, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        run_frame("good32", 8'h3C, 32, 1'b0, 1'b0, 1'b1, 1'b1, -1);

        run_frame("par_even_ok", 8'h07, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        run_frame("par_even_bad", 8'h07, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        run_frame("par_odd_ok", 8'h07, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1);

        run_frame("framing", 8'h55, 16, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        run_frame("after_framing", 8'h12, 16, 1'b0, 1'b0, 1'b1, 1'b1, -1);

        // Start-bit glitch: three low cycles are rejected by the mid-bit vote.
        prescale = PW'(16); par_en = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        busy_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_in = 1'b0;
        end
        idle(30);
        check("glitch:busy_seen", 32'(busy_seen), 1);
        check("glitch:busy", 32'(busy), 0);
        check("glitch:strobes", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);

        run_frame("noise_bit2", 8'hF0, 16, 1'b0, 1'b0, 1'b1, 1'b1, 2);

        // Back-to-back frames with no idle gap.
        prescale = PW'(8); par_en = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        dv_q.delete();
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, -1, dummy);
        send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b1, -1, dummy);
        idle(12);
        model_pdata = 8'hFE;
        check("b2b:count", dv_cnt - dv0, 2);
        check("b2b:errors", (pe_cnt - pe0) + (se_cnt - se0), 0);
        check("b2b:first", (dv_q.size() > 0) ? 32'(dv_q[0]) : 32'hDEAD, 32'h01);
        check("b2b:second", (dv_q.size() > 1) ? 32'(dv_q[1]) : 32'hDEAD, 32'hFE);
        check("b2b:p_data", 32'(p_data), 32'(model_pdata));

        // Reset in the middle of data bit 4.
        prescale = PW'(16);
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        rd = 8'hAA;
        drive_bit(1'b0, 16, 1'b0);
        for (int k = 0; k < 4; k++) drive_bit(rd[k], 16, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_in = rd[4];
        end
        check("midrst:busy_before", 32'(busy), 1);
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        rx_in = 1'b1;
        model_pdata = '0;
        check("midrst:busy", 32'(busy), 0);
        idle(40);
        check("midrst:strobes", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        check("midrst:p_data", 32'(p_data), 0);
        run_frame("after_rst", 8'h99, 16, 1'b0, 1'b0, 1'b1, 1'b1, -1);

        for (int n = 0; n < 12; n++) begin
            rd    = DW'($urandom);
            rps   = ps_tab[$urandom_range(0, 2)];
            rpe   = 1'($urandom);
            rpt   = 1'($urandom);
            rok   = ($urandom_range(0, 3) != 0);
            rstop = ($urandom_range(0, 5) != 0);
            run_frame($sformatf("rand%0d", n), rd, rps, rpe, rpt, rok, rstop,
                      int'($urandom_range(0, 15)));
        end

        check("strobe_width", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
